// File: rtl/rs_gf16_pkg.sv
// Shared GF(2^4) constants, alpha power table and types for the RS(15,11) syndrome block.
package rs_gf16_pkg;

    localparam int unsigned SYMW = 4;
    localparam int unsigned N    = 15;
    localparam int unsigned K    = 11;
    localparam int unsigned NSYM = N - K;
    localparam logic [4:0]  POLY = 5'h13;

    // Builds alpha^0..alpha^14 packed LSB-first, reducing by x^4+x+1 at each doubling.
    function automatic logic [N*SYMW-1:0] build_alpha_tbl();
        logic [4:0]          v;
        logic [N*SYMW-1:0]   t;
        v = 5'h01;
        t = '0;
        for (int unsigned i = 0; i < N; i++) begin
            t[i*SYMW +: SYMW] = v[SYMW-1:0];
            v = {v[SYMW-1:0], 1'b0};
            if (v[SYMW]) begin
                v = v ^ POLY;
            end
        end
        return t;
    endfunction

    localparam logic [N*SYMW-1:0] ALPHA_TBL = build_alpha_tbl();

    // alpha^e for any non-negative exponent; the multiplicative group has order 15.
    function automatic logic [SYMW-1:0] alpha_pow(input int unsigned e);
        return ALPHA_TBL[(e % N)*SYMW +: SYMW];
    endfunction

    typedef enum logic {
        ST_ACCUM = 1'b0,
        ST_HOLD  = 1'b1
    } state_e;

    // Syndrome set as presented to the consumer, S1 in the low nibble.
    typedef struct packed {
        logic [SYMW-1:0] s4;
        logic [SYMW-1:0] s3;
        logic [SYMW-1:0] s2;
        logic [SYMW-1:0] s1;
    } synd_t;

endpackage

// File: rtl/rs_syndrome_if.sv
// Symbol-in / syndrome-out valid-ready bus of the syndrome calculator.
interface rs_syndrome_if;
    import rs_gf16_pkg::*;

    logic                 in_valid;
    logic                 in_ready;
    logic [SYMW-1:0]      in_data;
    logic                 out_valid;
    logic                 out_ready;
    synd_t                out_syndromes;
    logic                 out_error;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_syndromes, out_error
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_syndromes, out_error
    );

endinterface

// File: rtl/gf16_mul_const.sv
// Multiply a GF(2^4) symbol by the constant alpha^EXP; pure XOR network.
module gf16_mul_const
    import rs_gf16_pkg::*;
#(
    parameter int unsigned EXP = 1
) (
    input  logic [SYMW-1:0] a_i,
    output logic [SYMW-1:0] prod_o
);

    // Each set input bit x^i contributes the constant column alpha^(EXP+i).
    always_comb begin
        prod_o = '0;
        for (int unsigned i = 0; i < SYMW; i++) begin
            if (a_i[i]) begin
                prod_o = prod_o ^ alpha_pow(EXP + i);
            end
        end
    end

endmodule

// File: rtl/rs_syndrome.sv
// RS(15,11) syndrome calculator: Horner accumulation of S1..S4 over 15 symbols, then hold.
module rs_syndrome #(
    parameter int unsigned SYMW = 4,
    parameter int unsigned NSYM = 4
) (
    input  logic           sys_clk,
    input  logic           sys_rst_n,
    rs_syndrome_if.slave   bus
);
    import rs_gf16_pkg::state_e;
    import rs_gf16_pkg::ST_ACCUM;
    import rs_gf16_pkg::ST_HOLD;
    import rs_gf16_pkg::N;

    localparam int unsigned CNTW     = 4;
    localparam logic [CNTW-1:0] CNT_LAST = CNTW'(N - 1);

    state_e              state_q, state_d;
    logic [CNTW-1:0]     cnt_q, cnt_d;
    logic [SYMW-1:0]     acc_q [NSYM];
    logic [SYMW-1:0]     acc_d [NSYM];
    logic [SYMW-1:0]     mul_w [NSYM];
    logic [NSYM*SYMW-1:0] synd_flat;

    // One constant multiplier per syndrome: S_j * alpha^j.
    for (genvar j = 0; j < NSYM; j++) begin : g_mul
        gf16_mul_const #(.EXP(j + 1)) u_mul (
            .a_i    (acc_q[j]),
            .prod_o (mul_w[j])
        );
    end

    // State, symbol counter and accumulator registers.
    always_ff @(posedge sys_clk or negedge sys_rst_n) begin
        if (!sys_rst_n) begin
            state_q <= ST_ACCUM;
            cnt_q   <= '0;
            for (int unsigned j = 0; j < NSYM; j++) begin
                acc_q[j] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            acc_q   <= acc_d;
        end
    end

    // Next state: accumulate on each accepted symbol, hold the result until it is taken.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        acc_d   = acc_q;
        case (state_q)
            ST_ACCUM: begin
                if (bus.in_valid) begin
                    for (int unsigned j = 0; j < NSYM; j++) begin
                        acc_d[j] = mul_w[j] ^ bus.in_data;
                    end
                    if (cnt_q == CNT_LAST) begin
                        cnt_d   = '0;
                        state_d = ST_HOLD;
                    end else begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                end
            end
            ST_HOLD: begin
                if (bus.out_ready) begin
                    for (int unsigned j = 0; j < NSYM; j++) begin
                        acc_d[j] = '0;
                    end
                    state_d = ST_ACCUM;
                end
            end
            default: begin
                state_d = ST_ACCUM;
            end
        endcase
    end

    // Outputs decoded purely from registers; no input reaches them combinationally.
    always_comb begin
        synd_flat = '0;
        for (int unsigned j = 0; j < NSYM; j++) begin
            synd_flat[j*SYMW +: SYMW] = acc_q[j];
        end
        bus.in_ready      = (state_q == ST_ACCUM);
        bus.out_valid     = (state_q == ST_HOLD);
        bus.out_syndromes = synd_flat;
        bus.out_error     = |synd_flat;
    end

endmodule

// File: doc/rs_syndrome.md
RS_SYNDROME -- requirements
Module: rs_syndrome

Interface
REQ-001 Parameter SYMW, default 4, symbol width in bits (GF(2^4)); only the value 4 is supported.
REQ-002 Parameter NSYM, default 4, number of syndromes (parity symbols); RS(15,11).
REQ-003 sys_clk  input  1  single clock; all state changes on the rising edge.
REQ-004 sys_rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 in_valid  input  1  in_data holds a received symbol.
REQ-006 in_ready  output  1  block accepts a symbol this cycle.
REQ-007 in_data  input  4  received symbol; highest-degree coefficient r14 first, r0 last.
REQ-008 out_valid  output  1  syndrome set available.
REQ-009 out_ready  input  1  consumer accepts the syndrome set.
REQ-010 out_syndromes  output  16  {S4,S3,S2,S1}, with S1 in bits [3:0].
REQ-011 out_error  output  1  high when any syndrome is nonzero.

Function
REQ-012 Field arithmetic SHALL be GF(2^4) with primitive polynomial x^4+x+1, where alpha = 4'h2.
REQ-013 A symbol transfers only on a cycle where in_valid and in_ready are both high.
REQ-014 On each transfer, every j in 1..4 SHALL update S_j <= (S_j * alpha^j) XOR in_data (Horner form).
REQ-015 Multiplication by alpha^j SHALL be a fixed XOR network with no registers inside it.
REQ-016 A 4-bit symbol counter SHALL count accepted symbols 0..14.
REQ-017 On the transfer where the counter is 14, the counter SHALL wrap to 0 and the state SHALL go ACCUM -> HOLD.
REQ-018 The accumulators SHALL keep the final syndromes, which are S_j = r(alpha^j).
REQ-019 FSM states: ACCUM (in_ready=1, out_valid=0) and HOLD (in_ready=0, out_valid=1).
REQ-020 in_ready and out_valid SHALL be decoded from the state register only, with no combinational path from an input.
REQ-021 In HOLD, out_syndromes and out_error SHALL stay stable until out_ready is sampled high.
REQ-022 While out_ready stays low, HOLD SHALL persist for any number of cycles.
REQ-023 On the HOLD cycle where out_ready is high, the accumulators SHALL clear to 0 and the state SHALL return to ACCUM.
REQ-024 in_ready SHALL be high on the cycle after that handshake, so result-to-next-symbol latency is 1 cycle.
REQ-025 Latency: out_valid SHALL rise in the cycle after the 15th symbol transfer.
REQ-026 Throughput: one block per 16 cycles when both sides are always ready.
REQ-027 in_data SHALL be ignored while in_valid=0 or in HOLD; counter and accumulators SHALL not change then.
REQ-028 out_error SHALL equal the OR of all out_syndromes bits; its value is defined only while out_valid=1.

Reset
REQ-029 On sys_rst_n low, state SHALL go to ACCUM and counter and accumulators SHALL go to 0.
REQ-030 The reset values of all outputs SHALL be in_ready=1, out_valid=0, out_syndromes=16'h0000, out_error=0.
REQ-031 Reset asserted in mid-block or in HOLD SHALL discard the partial or pending result, and no out_valid SHALL follow.
REQ-032 Release of reset SHALL be synchronized to sys_clk externally, and the first transfer SHALL be possible on the first edge after release.

Structure
REQ-033 A shared package rs_gf16_pkg SHALL hold the constants SYMW=4, N=15, K=11, NSYM=4 and POLY=5'h13, plus the alpha power table.
REQ-034 Exactly one sub-module, gf16_mul_const (a constant-multiply XOR network, parameter EXP = power of alpha), SHALL be instantiated once per syndrome.
REQ-035 The FSM, counter and accumulators SHALL live in rs_syndrome, with target size 120-250 lines.

Verification
REQ-036 Stream 15 zero symbols with both sides always ready -> out_valid in cycle 16, out_syndromes=16'h0000, out_error=0.
REQ-037 Stream 14 zeros then 4'h1 (r0=1) -> out_syndromes=16'h1111, out_error=1.
REQ-038 Stream 4'h1 then 14 zeros (r14=1) -> out_syndromes=16'hEFD9 (S1=9, S2=D, S3=F, S4=E).
REQ-039 Encode a valid RS(15,11) codeword with the team encoder and send it -> syndromes 0.
  - Then flip one symbol -> out_error=1 and the syndromes match the golden model.
REQ-040 Hold out_ready low for 20 cycles with in_valid high -> in_ready=0 throughout and outputs stable.
  - Raise out_ready -> the next block is accepted one cycle later and starts from zero accumulators.
REQ-041 Randomize in_valid gaps, then assert sys_rst_n low after 7 symbols -> all outputs at reset values.
  - A full 15-symbol block sent after release -> correct syndromes with no residue from the aborted block.
